fht_twiddle_gen: RTL and testbench



---
 rtl/fht_twiddle_gen_if.sv | 29 ++
 rtl/fht_twiddle_gen.sv | 185 ++++++++++++++++++
 tb/tb_fht_twiddle_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fht_twiddle_gen_if.sv
// Purpose: start/stage control plus the (sin, cos) twiddle stream between fht_twiddle_gen and its consumer.
// Ports: iSTART/iSTAGE start a stage; oVALID/iREADY handshake oSIN/oCOS/oIDX/oLAST; oBUSY/oDONE report status.
// master = generator side, slave = controller/consumer side.
interface fht_twiddle_gen_if #(
  parameter int LOG_N = 8,
  parameter int W_BIT = 16,
  parameter int ST_W  = $clog2(LOG_N)
);
  logic                    iSTART;
  logic [ST_W-1:0]         iSTAGE;
  logic                    iREADY;
  logic                    oVALID;
  logic signed [W_BIT-1:0] oSIN;
  logic signed [W_BIT-1:0] oCOS;
  logic [LOG_N-2:0]        oIDX;
  logic                    oLAST;
  logic                    oBUSY;
  logic                    oDONE;

  modport master (
    input  iSTART, iSTAGE, iREADY,
    output oVALID, oSIN, oCOS, oIDX, oLAST, oBUSY, oDONE
  );

  modport slave (
    output iSTART, iSTAGE, iREADY,
    input  oVALID, oSIN, oCOS, oIDX, oLAST, oBUSY, oDONE
  );
endinterface

// File: rtl/fht_twiddle_gen.sv
// Purpose: issues one scaled (sin, cos) twiddle pair per butterfly of stage s, in issue order.
// Ports: iCLK, iRESET (async, active-high); tw = fht_twiddle_gen_if.master (start/stage in, pair stream out).
// Latency 3 cycles from accepted start, then 1 pair/cycle; oVALID & ~iREADY stalls the whole pipeline.
// Build option FHT_TW_QUARTER_ROM_EN: quarter-wave table + symmetry logic; undefined: two half-wave tables.
module fht_twiddle_gen #(
  parameter int LOG_N      = 8,
  parameter int W_BIT      = 16,
  parameter int HALF_W_MAX = 8192,
  parameter int ST_W       = $clog2(LOG_N)
) (
  input  logic              iCLK,
  input  logic              iRESET,
  fht_twiddle_gen_if.master tw
);
  localparam int  N  = 1 << LOG_N;
  localparam int  NH = N / 2;
  localparam int  NQ = N / 4;
  localparam int  KW = LOG_N - 1;
  localparam int  S  = 2 * HALF_W_MAX;
  localparam real PI = 3.14159265358979323846;

  // round(S*sin(2*pi*m/N)); the argument stays in [0, pi/2] so the value is never negative
  function automatic int qval(input int m);
    real v;
    v = real'(S) * $sin(2.0 * PI * real'(m) / real'(N));
    return $rtoi(v + 0.5);
  endfunction

`ifdef FHT_TW_QUARTER_ROM_EN
  function automatic logic [(NQ+1)*W_BIT-1:0] gen_q();
    logic [(NQ+1)*W_BIT-1:0] t;
    t = '0;
    for (int m = 0; m <= NQ; m++) t[m*W_BIT +: W_BIT] = W_BIT'(qval(m));
    return t;
  endfunction
  localparam logic [(NQ+1)*W_BIT-1:0] QTAB = gen_q();
`else
  // Half-wave tables are derived from the same quarter values so both builds are bit-identical
  function automatic logic [NH*W_BIT-1:0] gen_half(input bit is_cos);
    logic [NH*W_BIT-1:0] t;
    int                  v;
    t = '0;
    for (int k = 0; k < NH; k++) begin
      if (is_cos) v = (k <= NQ) ? qval(NQ - k) : -qval(k - NQ);
      else        v = (k <= NQ) ? qval(k)      : qval(NH - k);
      t[k*W_BIT +: W_BIT] = W_BIT'(v);
    end
    return t;
  endfunction
  localparam logic [NH*W_BIT-1:0] SIN_TAB = gen_half(1'b0);
  localparam logic [NH*W_BIT-1:0] COS_TAB = gen_half(1'b1);
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ST_W-1:0]   stage_q, stage_d;
  logic [KW-1:0]     cnt_q, cnt_d;
  logic              issue, adv, last_hs, done_q;
  logic [31:0]       stage_ext;
  logic [KW-1:0]     mask, k_c;
  logic [31:0]       shamt;

  logic              p1_vld_q, p2_vld_q, out_vld_q, out_last_q;
  logic [KW-1:0]     p1_idx_q, p1_k_q, p2_idx_q, out_idx_q;
  logic signed [W_BIT-1:0] p2_sin_q, p2_cos_q, out_sin_q, out_cos_q;
  logic signed [W_BIT-1:0] rd_sin, rd_cos, cos_sel;

  assign adv       = ~out_vld_q | tw.iREADY;
  assign last_hs   = out_vld_q & tw.iREADY & out_last_q;
  // 32-bit compare keeps the illegal-stage guard meaningful whatever ST_W is
  assign stage_ext = 32'(tw.iSTAGE);

  // k = (cnt & (2^s-1)) << (LOG_N-1-s)
  assign mask  = KW'((32'd1 << stage_q) - 32'd1);
  assign shamt = 32'(KW) - 32'(stage_q);
  assign k_c   = KW'(32'(cnt_q & mask) << shamt);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: if (tw.iSTART && (stage_ext < 32'(LOG_N))) begin
        state_d = RUN;
        stage_d = tw.iSTAGE;
        cnt_d   = '0;
      end
      RUN: if (adv) begin
        issue = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == KW'(NH - 1)) state_d = DRAIN;
      end
      DRAIN: if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      done_q  <= last_hs;
    end
  end

`ifdef FHT_TW_QUARTER_ROM_EN
  logic          p1_hi_q, p2_neg_q;
  logic [KW-1:0] sin_a, cos_a;

  // Fold the second quadrant onto the quarter table; cos picks up a sign flip there
  always_comb begin
    if (p1_hi_q) begin
      sin_a = KW'(NH) - p1_k_q;
      cos_a = p1_k_q - KW'(NQ);
    end else begin
      sin_a = p1_k_q;
      cos_a = KW'(NQ) - p1_k_q;
    end
  end
  assign rd_sin  = QTAB[int'(sin_a)*W_BIT +: W_BIT];
  assign rd_cos  = QTAB[int'(cos_a)*W_BIT +: W_BIT];
  assign cos_sel = p2_neg_q ? -p2_cos_q : p2_cos_q;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      p1_hi_q  <= 1'b0;
      p2_neg_q <= 1'b0;
    end else if (adv) begin
      p1_hi_q  <= (k_c > KW'(NQ));
      p2_neg_q <= p1_hi_q;
    end
  end
`else
  assign rd_sin  = SIN_TAB[int'(p1_k_q)*W_BIT +: W_BIT];
  assign rd_cos  = COS_TAB[int'(p1_k_q)*W_BIT +: W_BIT];
  assign cos_sel = p2_cos_q;
`endif

  // P1: index -> k; P2: table read; P3: sign/select into output registers
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      p1_vld_q   <= 1'b0;
      p1_idx_q   <= '0;
      p1_k_q     <= '0;
      p2_vld_q   <= 1'b0;
      p2_idx_q   <= '0;
      p2_sin_q   <= '0;
      p2_cos_q   <= '0;
      out_vld_q  <= 1'b0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
      out_sin_q  <= '0;
      out_cos_q  <= '0;
    end else if (adv) begin
      p1_vld_q   <= issue;
      p1_idx_q   <= cnt_q;
      p1_k_q     <= k_c;
      p2_vld_q   <= p1_vld_q;
      p2_idx_q   <= p1_idx_q;
      p2_sin_q   <= rd_sin;
      p2_cos_q   <= rd_cos;
      out_vld_q  <= p2_vld_q;
      out_idx_q  <= p2_idx_q;
      out_last_q <= p2_vld_q & (p2_idx_q == KW'(NH - 1));
      out_sin_q  <= p2_sin_q;
      out_cos_q  <= cos_sel;
    end
  end

  assign tw.oVALID = out_vld_q;
  assign tw.oSIN   = out_sin_q;
  assign tw.oCOS   = out_cos_q;
  assign tw.oIDX   = out_idx_q;
  assign tw.oLAST  = out_last_q;
  assign tw.oBUSY  = (state_q != IDLE);
  assign tw.oDONE  = done_q;
endmodule

// File: tb/tb_fht_twiddle_gen.sv
module tb_fht_twiddle_gen;
  localparam int  LOG_N = 8;
  localparam int  N     = 256;
  localparam int  NH    = 128;
  localparam int  S     = 16384;
  localparam int  ST_W  = 4;
  localparam real PI    = 3.14159265358979323846;

  logic iCLK, iRESET;
  fht_twiddle_gen_if #(.LOG_N(LOG_N), .W_BIT(16), .ST_W(ST_W)) tw_if ();

  fht_twiddle_gen #(.LOG_N(LOG_N), .W_BIT(16), .HALF_W_MAX(8192), .ST_W(ST_W)) dut (
    .iCLK  (iCLK),
    .iRESET(iRESET),
    .tw    (tw_if)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int n_chk = 0;
  int n_err = 0;
  int exp_idx = 0;
  int cur_stage = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rnd(input real x);
    return $rtoi($floor(x + 0.5));
  endfunction

  // Reference pair straight from the angle definition
  task automatic model(input int s, input int i, output int es, output int ec);
    int  k;
    real a;
    k  = (i % (1 << s)) * (1 << (LOG_N - 1 - s));
    a  = 2.0 * PI * real'(k) / real'(N);
    es = rnd(real'(S) * $sin(a));
    ec = rnd(real'(S) * $cos(a));
  endtask

  function automatic longint out_bus();
    return longint'({tw_if.oVALID, tw_if.oLAST, tw_if.oIDX, tw_if.oSIN, tw_if.oCOS,
                     tw_if.oBUSY, tw_if.oDONE});
  endfunction

  // Compare process
  bit     prev_lhs = 1'b0;
  bit     prev_stall = 1'b0;
  longint snap = 0;

  always @(negedge iCLK) begin
    int es, ec;
    longint c, s2;
    if (chk_en && !iRESET) begin
      chk("done_pulse", tw_if.oDONE, prev_lhs);
      if (prev_stall) chk("hold_stable", longint'({tw_if.oVALID, tw_if.oLAST, tw_if.oIDX, tw_if.oSIN, tw_if.oCOS}), snap);
      if (tw_if.oVALID) begin
        model(cur_stage, exp_idx, es, ec);
        chk("idx", tw_if.oIDX, exp_idx);
        chk("sin", tw_if.oSIN, es);
        chk("cos", tw_if.oCOS, ec);
        chk("last", tw_if.oLAST, (exp_idx == NH - 1) ? 1 : 0);
        chk("busy_while_valid", tw_if.oBUSY, 1);
        c  = longint'(tw_if.oCOS);
        s2 = longint'(tw_if.oSIN);
        chk("norm", ((c*c + s2*s2 - longint'(S)*S) <= 2*S && (c*c + s2*s2 - longint'(S)*S) >= -2*S) ? 1 : 0, 1);
        if (cur_stage == 0) begin
          chk("s0_cos", tw_if.oCOS, 16384);
          chk("s0_sin", tw_if.oSIN, 0);
        end
        if (cur_stage == 1) begin
          chk("s1_cos", tw_if.oCOS, exp_idx[0] ? 0 : 16384);
          chk("s1_sin", tw_if.oSIN, exp_idx[0] ? 16384 : 0);
        end
        if (cur_stage == 7 && exp_idx == 32) begin
          chk("s7_i32_cos", tw_if.oCOS, 11585);
          chk("s7_i32_sin", tw_if.oSIN, 11585);
        end
        if (cur_stage == 7 && exp_idx == 64) begin
          chk("s7_i64_cos", tw_if.oCOS, 0);
          chk("s7_i64_sin", tw_if.oSIN, 16384);
        end
        if (cur_stage == 7 && exp_idx == 96) begin
          chk("s7_i96_cos", tw_if.oCOS, -11585);
          chk("s7_i96_sin", tw_if.oSIN, 11585);
        end
      end
      prev_lhs   = tw_if.oVALID & tw_if.iREADY & tw_if.oLAST;
      prev_stall = tw_if.oVALID & ~tw_if.iREADY;
      snap       = longint'({tw_if.oVALID, tw_if.oLAST, tw_if.oIDX, tw_if.oSIN, tw_if.oCOS});
      if (tw_if.oVALID && tw_if.iREADY) exp_idx++;
    end else begin
      prev_lhs   = 1'b0;
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // mode 0: iREADY high; 1: 5-cycle stall at idx 40 then random; 2: reset at idx 50
  // Returns in the oDONE cycle, so a following call starts there.
  task automatic run_stage(input int s, input int mode, input bit inj_start);
    int t, lat, hold;
    bit done, seen40;
    exp_idx   = 0;
    cur_stage = s;
    tw_if.iSTAGE = ST_W'(s);
    tw_if.iSTART = 1'b1;
    tw_if.iREADY = 1'b1;
    tick();
    t = 0; lat = -1; hold = 0; done = 1'b0; seen40 = 1'b0;
    while (t < 1000) begin
      tw_if.iSTART = 1'b0;
      if (tw_if.oDONE) begin
        done = 1'b1;
        break;
      end
      if (lat < 0 && tw_if.oVALID) lat = t;
      if (mode == 2 && tw_if.oVALID && exp_idx == 50) begin
        chk_en = 1'b0;
        iRESET = 1'b1;
        #1;
        chk("async_reset_outputs", out_bus(), 0);
        tick();
        tick();
        iRESET = 1'b0;
        #1;
        chk("post_reset_outputs", out_bus(), 0);
        chk_en = 1'b1;
        return;
      end
      if (inj_start && tw_if.oVALID && exp_idx == 20) begin
        tw_if.iSTART = 1'b1;
        tw_if.iSTAGE = ST_W'(3);
      end
      if (mode == 1) begin
        if (tw_if.oVALID && exp_idx == 40 && !seen40) begin
          seen40 = 1'b1;
          hold   = 5;
        end
        if (hold > 0) begin
          tw_if.iREADY = 1'b0;
          hold--;
        end else if (seen40) begin
          tw_if.iREADY = 1'($urandom_range(0, 1));
        end else begin
          tw_if.iREADY = 1'b1;
        end
      end else begin
        tw_if.iREADY = 1'b1;
      end
      tick();
      t++;
    end
    tw_if.iREADY = 1'b1;
    chk("done_seen", done, 1);
    chk("first_valid_latency", lat, 3);
    chk("accepted_count", exp_idx, NH);
    chk("busy_low_at_done", tw_if.oBUSY, 0);
    if (mode == 0) chk("cycles_to_done", t, NH + 3);
  endtask

  initial begin
    tw_if.iSTART = 1'b0;
    tw_if.iSTAGE = '0;
    tw_if.iREADY = 1'b1;
    iRESET = 1'b1;
    #12;
    chk("reset_outputs", out_bus(), 0);
    tick();
    iRESET = 1'b0;
    tick();
    chk("idle_outputs", out_bus(), 0);
    chk_en = 1'b1;

    run_stage(0, 0, 1'b0);
    run_stage(1, 0, 1'b0);
    run_stage(7, 0, 1'b1);
    run_stage(7, 1, 1'b0);
    run_stage(7, 2, 1'b0);
    run_stage(2, 0, 1'b0);

    // Stage 8 is out of range and must not start anything
    tw_if.iSTAGE = ST_W'(8);
    tw_if.iSTART = 1'b1;
    tick();
    tw_if.iSTART = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("illegal_stage_busy", tw_if.oBUSY, 0);
      chk("illegal_stage_valid", tw_if.oVALID, 0);
      tick();
    end

    for (int s = 0; s < LOG_N; s++) run_stage(s, 0, 1'b0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
